router_ingress_ctrl: RTL
========================

// Module: router_ingress_ctrl
// PURPOSE
//  Ingress stage of the 1x3 router, directly upstream of the three router_fifo instances.
//  Accepts the source byte stream (header, payload, parity), decodes the destination and
//  steers every byte into the selected FIFO with write_enb/lfd_state/dout.
//  Back-pressures the source via busy, checks packet parity and flags err.
//  Header format: data_in[1:0]=dest addr (0..2; 3 = invalid), data_in[7:2]=payload length.
// PARAMETERS
//  WIDTH          8   byte width; header fields fixed at [1:0]/[7:2]
//  TIMEOUT_CYCLES 30  unread-output cycles before soft_reset (feature macro only)
// PORTS
//  clock       in  1      system clock, all logic on rising edge
//  reset       in  1      synchronous, active-high reset
//  data_in     in  WIDTH  source byte
//  pkt_valid   in  1      high for header+payload bytes; low on the parity byte
//  busy        out 1      1 = source must hold data_in/pkt_valid (byte not accepted)
//  err         out 1      parity mismatch on last packet
//  fifo_full   in  3      router_fifo full flags
//  fifo_empty  in  3      router_fifo empty flags
//  read_enb    in  3      destination read strobes (timeout monitor)
//  write_enb   out 3      one-hot FIFO write strobe
//  lfd_state   out 1      high exactly 1 cycle before the header write (FIFO delays it 1 cycle)
//  dout        out WIDTH  byte to FIFOs (registered)
//  valid_out   out 3      ~fifo_empty, combinational
//  soft_reset  out 3      per-FIFO soft reset pulse
// BEHAVIOUR
//  - Reset: state=DECODE_ADDRESS, write_enb=0, lfd_state=0, dout=0, err=0, soft_reset=0,
//    pending=0, parity accumulator=0; busy=0. Reset mid-packet aborts; remaining bytes dropped.
//  - Byte accepted in any cycle with busy=0 and (pkt_valid=1 or state==LOAD_DATA).
//  - 1-deep write buffer: accepted byte -> dout, pending=1; write_enb[addr]=pending.
//    Write taken = pending & ~fifo_full[addr]; not taken -> dout/write_enb held, retried.
//    busy=1 whenever pending & fifo_full[addr] (combinational); no byte ever lost/duplicated.
//  - FSM:
//    DECODE_ADDRESS: busy=0; pkt_valid&addr<3: latch header, addr, parity=header;
//      -> LOAD_FIRST_DATA if fifo_empty[addr] else WAIT_TILL_EMPTY. addr==3 -> DROP.
//    WAIT_TILL_EMPTY: busy=1; fifo_empty[addr] -> LOAD_FIRST_DATA.
//    LOAD_FIRST_DATA: busy=1, lfd_state=1, dout<=header, pending=1 -> LOAD_DATA (1 cycle).
//      Header write is never blocked (FIFO is empty).
//    LOAD_DATA: accept payload while pkt_valid=1, parity^=byte; first accepted byte with
//      pkt_valid=0 is the packet parity byte: latch it, write it to FIFO -> LOAD_PARITY.
//    LOAD_PARITY: busy=1 until parity write taken -> CHECK_PARITY_ERROR.
//    CHECK_PARITY_ERROR: busy=1; err<=(accum!=packet parity); -> DECODE_ADDRESS (1 cycle).
//    DROP: busy=0, bytes discarded, no writes; first cycle pkt_valid=0 -> DECODE_ADDRESS.
//  - err holds its value until the next valid header is latched (then cleared).
//  - Latency: header on data_in cycle N -> lfd_state N+1 -> write_enb N+2; payload N -> N+1.
//  - Length field is carried, not enforced; framing is by pkt_valid only.
//  - soft_reset[addr] during an active packet: pending cleared, write_enb=0,
//    -> DROP if pkt_valid=1 else DECODE_ADDRESS; err unchanged.
// CONFIGURATION
//  ROUTER_SOFT_RESET_TIMEOUT_EN defined: per-port 5-bit counter increments while
//    valid_out[i]=1 & read_enb[i]=0, clears on read_enb[i]=1 or valid_out[i]=0;
//    reaching TIMEOUT_CYCLES -> soft_reset[i]=1 for 1 cycle, counter cleared.
//  Not defined: soft_reset tied to 3'b000; read_enb unused; no counters.
// TESTING
//  1 Hdr 8'h0D, payload 11,22,33, parity 8'h0D -> write_enb[1] 5 writes in order, lfd_state
//    1 cycle before header write, FIFO1 gets 0D,11,22,33,0D, err=0.
//  2 Same packet, parity 8'h0E -> all 5 bytes written, err=1 after CHECK_PARITY_ERROR,
//    err cleared on next valid header.
//  3 fifo_full[0]=1 for 4 cycles mid-payload -> busy=1, dout/write_enb[0] held, no byte
//    lost/duplicated after release.
//  4 fifo_empty[2]=0 at header 8'h06 -> busy=1, write_enb=0 until fifo_empty[2]=1, then normal.
//  5 Header 8'h0B (addr 3) -> write_enb stays 3'b000, busy=0, FSM back to DECODE after parity.
//  6 Macro on: valid_out[0]=1, read_enb[0]=0 for 30 cycles -> soft_reset[0] pulses on cycle 30;
//    macro off -> soft_reset stays 0. Reset mid-packet -> all outputs to reset values.

Source files
------------

// File: rtl/router_ingress_ctrl_if.sv
// -----------------------------------------------------------------------------
// router_ingress_ctrl_if
// Bundles the ingress controller's source-side and FIFO-side signals.
//
// Handshake: the source presents data_in/pkt_valid and must hold both
// unchanged while busy=1. A byte is taken on a rising clock edge when
// busy=0 and either pkt_valid=1 or the controller is in LOAD_DATA.
// On the FIFO side, a write lands in FIFO i on a rising edge where
// write_enb[i]=1 and fifo_full[i]=0. Until then dout and write_enb are held.
//
// Signals (the slave modport is the controller's view):
//   data_in    source byte                  pkt_valid  header/payload marker
//   busy       source must hold             err        parity mismatch flag
//   fifo_full  router_fifo full flags       fifo_empty router_fifo empty flags
//   read_enb   destination read strobes     write_enb  one-hot FIFO write strobe
//   lfd_state  header-write marker          dout       byte to the FIFOs
//   valid_out  ~fifo_empty                  soft_reset per-FIFO soft reset pulse
//   state_dbg  controller FSM state, for observation only
// -----------------------------------------------------------------------------
interface router_ingress_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             pkt_valid;
  logic             busy;
  logic             err;
  logic [2:0]       fifo_full;
  logic [2:0]       fifo_empty;
  logic [2:0]       read_enb;
  logic [2:0]       write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] dout;
  logic [2:0]       valid_out;
  logic [2:0]       soft_reset;
  logic [2:0]       state_dbg;

  modport slave (
    input  data_in, pkt_valid, fifo_full, fifo_empty, read_enb,
    output busy, err, write_enb, lfd_state, dout, valid_out, soft_reset, state_dbg
  );

  modport master (
    output data_in, pkt_valid, fifo_full, fifo_empty, read_enb,
    input  busy, err, write_enb, lfd_state, dout, valid_out, soft_reset, state_dbg
  );
endinterface

// File: rtl/router_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// router_ingress_ctrl
// Ingress stage of the 1x3 router. Decodes the destination from the header
// byte (bits [1:0], 3 = invalid), steers header, payload and parity bytes
// into the selected router_fifo through a 1-deep write buffer, stalls the
// source with busy, and checks the packet parity (err).
//
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    router_ingress_ctrl_if.slave (all data/handshake/FIFO signals)
//
// Optional feature macro: ROUTER_SOFT_RESET_TIMEOUT_EN
//   Defined:   per-port unread-output timeout counters drive soft_reset.
//   Undefined: soft_reset is tied low and read_enb is ignored.
//
// state_dbg encoding: 0 DECODE_ADDRESS, 1 WAIT_TILL_EMPTY, 2 LOAD_FIRST_DATA,
//   3 LOAD_DATA, 4 LOAD_PARITY, 5 CHECK_PARITY_ERROR, 6 DROP.
// -----------------------------------------------------------------------------
module router_ingress_ctrl #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic                 clock,
  input  logic                 reset,
  router_ingress_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    WAIT_TILL_EMPTY    = 3'd1,
    LOAD_FIRST_DATA    = 3'd2,
    LOAD_DATA          = 3'd3,
    LOAD_PARITY        = 3'd4,
    CHECK_PARITY_ERROR = 3'd5,
    DROP               = 3'd6
  } state_t;

  state_t           r_state;
  logic [1:0]       r_addr;
  logic [WIDTH-1:0] r_header;
  logic [WIDTH-1:0] r_parity_acc;
  logic [WIDTH-1:0] r_pkt_parity;
  logic [WIDTH-1:0] r_dout;
  logic             r_pending;
  logic             r_lfd;
  logic             r_err;

  logic [1:0]       w_addr_in;
  logic [2:0]       w_sel;
  logic [2:0]       w_sel_in;
  logic             w_full_sel;
  logic             w_empty_sel;
  logic             w_empty_in;
  logic             w_block;
  logic             w_taken;
  logic             w_busy;
  logic             w_accept;
  logic             w_active;
  logic             w_soft_hit;
  logic [2:0]       w_soft_reset;
  logic [2:0]       w_valid_out;

  function automatic logic [2:0] addr_onehot(input logic [1:0] a);
    case (a)
      2'd0:    addr_onehot = 3'b001;
      2'd1:    addr_onehot = 3'b010;
      2'd2:    addr_onehot = 3'b100;
      default: addr_onehot = 3'b000;
    endcase
  endfunction

  assign w_addr_in   = bus.data_in[1:0];
  assign w_sel       = addr_onehot(r_addr);
  assign w_sel_in    = addr_onehot(w_addr_in);
  assign w_full_sel  = |(bus.fifo_full & w_sel);
  assign w_empty_sel = |(bus.fifo_empty & w_sel);
  assign w_empty_in  = |(bus.fifo_empty & w_sel_in);
  assign w_valid_out = ~bus.fifo_empty;

  // Write buffer: the held byte is blocked while its FIFO is full.
  assign w_block = r_pending & w_full_sel;
  assign w_taken = r_pending & ~w_full_sel;

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      DECODE_ADDRESS:     w_busy = w_block;
      WAIT_TILL_EMPTY:    w_busy = 1'b1;
      LOAD_FIRST_DATA:    w_busy = 1'b1;
      LOAD_DATA:          w_busy = w_block;
      LOAD_PARITY:        w_busy = 1'b1;
      CHECK_PARITY_ERROR: w_busy = 1'b1;
      DROP:               w_busy = w_block;
      default:            w_busy = 1'b0;
    endcase
  end

  // In LOAD_DATA every non-busy cycle consumes a byte; pkt_valid only tells
  // payload from parity there.
  assign w_accept = ~w_busy & (bus.pkt_valid | (r_state == LOAD_DATA));

  // A packet is "active" once a valid header has been latched and until the
  // FSM returns to DECODE_ADDRESS.
  assign w_active   = (r_state != DECODE_ADDRESS) && (r_state != DROP);
  assign w_soft_hit = w_active & |(w_soft_reset & w_sel);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= DECODE_ADDRESS;
      r_addr       <= 2'd0;
      r_header     <= '0;
      r_parity_acc <= '0;
      r_pkt_parity <= '0;
      r_dout       <= '0;
      r_pending    <= 1'b0;
      r_lfd        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_lfd <= 1'b0;
      if (w_soft_hit) begin
        // The destination FIFO was flushed: abandon the packet, keep err.
        r_pending <= 1'b0;
        r_state   <= bus.pkt_valid ? DROP : DECODE_ADDRESS;
      end else begin
        case (r_state)
          DECODE_ADDRESS: begin
            if (w_accept) begin
              if (w_addr_in != 2'd3) begin
                r_header     <= bus.data_in;
                r_addr       <= w_addr_in;
                r_parity_acc <= bus.data_in;
                r_err        <= 1'b0;
                if (w_empty_in) begin
                  r_state <= LOAD_FIRST_DATA;
                  r_lfd   <= 1'b1;
                end else begin
                  r_state <= WAIT_TILL_EMPTY;
                end
              end else begin
                r_state <= DROP;
              end
            end
          end
          WAIT_TILL_EMPTY: begin
            if (w_empty_sel) begin
              r_state <= LOAD_FIRST_DATA;
              r_lfd   <= 1'b1;
            end
          end
          LOAD_FIRST_DATA: begin
            // The buffer is empty here: the previous parity write completed
            // before CHECK_PARITY_ERROR.
            r_dout    <= r_header;
            r_pending <= 1'b1;
            r_state   <= LOAD_DATA;
          end
          LOAD_DATA: begin
            if (w_accept) begin
              r_dout    <= bus.data_in;
              r_pending <= 1'b1;
              if (bus.pkt_valid) begin
                r_parity_acc <= r_parity_acc ^ bus.data_in;
              end else begin
                r_pkt_parity <= bus.data_in;
                r_state      <= LOAD_PARITY;
              end
            end else if (w_taken) begin
              r_pending <= 1'b0;
            end
          end
          LOAD_PARITY: begin
            if (w_taken) begin
              r_pending <= 1'b0;
              r_state   <= CHECK_PARITY_ERROR;
            end
          end
          CHECK_PARITY_ERROR: begin
            r_err   <= (r_parity_acc != r_pkt_parity);
            r_state <= DECODE_ADDRESS;
          end
          DROP: begin
            if (!bus.pkt_valid) begin
              r_state <= DECODE_ADDRESS;
            end
          end
          default: r_state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

`ifdef ROUTER_SOFT_RESET_TIMEOUT_EN
  logic [4:0] r_to_cnt [3];
  logic [2:0] r_soft_reset;

  // Counts consecutive cycles a port has data nobody reads; on reaching
  // TIMEOUT_CYCLES the port is flushed with a one-cycle soft_reset pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        r_to_cnt[i] <= '0;
      end
      r_soft_reset <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_soft_reset[i] <= 1'b0;
        if (w_valid_out[i] && !bus.read_enb[i]) begin
          if (r_to_cnt[i] == 5'(TIMEOUT_CYCLES - 1)) begin
            r_soft_reset[i] <= 1'b1;
            r_to_cnt[i]     <= '0;
          end else begin
            r_to_cnt[i] <= r_to_cnt[i] + 5'd1;
          end
        end else begin
          r_to_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_soft_reset = r_soft_reset;
`else
  logic [2:0] w_unused_read_enb;
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign w_unused_read_enb = bus.read_enb;
  assign w_soft_reset      = 3'b000;
`endif

  assign bus.busy       = w_busy;
  assign bus.err        = r_err;
  assign bus.write_enb  = r_pending ? w_sel : 3'b000;
  assign bus.lfd_state  = r_lfd;
  assign bus.dout       = r_dout;
  assign bus.valid_out  = w_valid_out;
  assign bus.soft_reset = w_soft_reset;
  assign bus.state_dbg  = r_state;

endmodule
